// File: rtl/lut_neuron_loader.sv
// Runtime-programmable LUT neuron: streams a 2^IN_BITS-entry truth table
// into registers, then serves registered single-cycle lookups from it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no table resident; lookups dropped
// S_LOAD  | accepting table beats at addr_q; lookups dropped
// S_READY | full table resident; lookups served with 1-cycle latency
module lut_neuron_loader #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic                lut_in_valid,
  input  logic [IN_BITS-1:0]  lut_in,
  output logic                lut_out_valid,
  output logic [OUT_BITS-1:0] lut_out,
  output logic                lut_drop
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

  state_t              state_q, state_d;
  logic [IN_BITS:0]    addr_q, addr_d;
  logic [OUT_BITS-1:0] tbl_q [DEPTH];
  logic [OUT_BITS-1:0] tbl_d [DEPTH];
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_q, out_d;
  logic                drop_q, drop_d;
  logic                beat;

  // Load sequencing: a restart always wins over a beat in the same cycle,
  // and only a completed load clears the abort flag.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    beat    = (state_q == S_LOAD) && cfg_valid && !cfg_start;
    if (cfg_start) begin
      state_d = S_LOAD;
      addr_d  = '0;
      if (state_q == S_LOAD) err_d = 1'b1;
    end else if (beat) begin
      tbl_d[addr_q[IN_BITS-1:0]] = cfg_data;
      addr_d = addr_q + 1'b1;
      if (addr_q == LAST_ADDR) begin
        state_d = S_READY;
        err_d   = 1'b0;
      end
    end
  end

  // Lookup path: served only from a resident table, otherwise flagged as dropped.
  // lut_out keeps its previous value whenever nothing is served.
  always_comb begin
    out_valid_d = 1'b0;
    drop_d      = 1'b0;
    out_d       = out_q;
    if (lut_in_valid) begin
      if (state_q == S_READY) begin
        out_valid_d = 1'b1;
        out_d       = tbl_q[lut_in];
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // State, table and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      addr_q      <= '0;
      tbl_q       <= '{default: '0};
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tbl_q       <= tbl_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
    end
  end

  assign cfg_ready     = (state_q == S_LOAD);
  assign cfg_done      = (state_q == S_READY);
  assign cfg_err       = err_q;
  assign lut_out_valid = out_valid_q;
  assign lut_out       = out_q;
  assign lut_drop      = drop_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Bench for lut_neuron_loader: random loads/lookups against a table-level model.
module tb_lut_neuron_loader;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 1;
  localparam int DEPTH    = 1 << IN_BITS;

  typedef logic [OUT_BITS-1:0] tbl_t [DEPTH];

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_start, cfg_valid, cfg_ready, cfg_done, cfg_err;
  logic [OUT_BITS-1:0] cfg_data;
  logic                lut_in_valid, lut_out_valid, lut_drop;
  logic [IN_BITS-1:0]  lut_in;
  logic [OUT_BITS-1:0] lut_out;

  lut_neuron_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .lut_in_valid(lut_in_valid), .lut_in(lut_in),
    .lut_out_valid(lut_out_valid), .lut_out(lut_out), .lut_drop(lut_drop)
  );

  always #5 clk = ~clk;

  // Model: the table the neuron should currently be serving, whether one is
  // resident at all, and the last value served.
  tbl_t                cur_tbl;
  bit                  resident;
  logic [OUT_BITS-1:0] last_out;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cfg_ready, 0);
    chk({tag, "_done"},  cfg_done, 0);
    chk({tag, "_err"},   cfg_err, 0);
    chk({tag, "_valid"}, lut_out_valid, 0);
    chk({tag, "_out"},   lut_out, 0);
    chk({tag, "_drop"},  lut_drop, 0);
  endtask

  // Present one lookup for one cycle and check the registered response.
  task automatic look(input logic [IN_BITS-1:0] code);
    lut_in_valid = 1'b1;
    lut_in       = code;
    step();
    lut_in_valid = 1'b0;
    if (resident) begin
      chk("lk_valid", lut_out_valid, 1);
      chk("lk_drop", lut_drop, 0);
      chk("lk_data", lut_out, cur_tbl[code]);
      last_out = cur_tbl[code];
    end else begin
      chk("lk_drop", lut_drop, 1);
      chk("lk_valid", lut_out_valid, 0);
      chk("lk_hold", lut_out, last_out);
    end
  endtask

  task automatic sweep();
    for (int c = 0; c < DEPTH; c++) look(IN_BITS'(c));
  endtask

  // Full load with random cfg_valid gaps; a lookup rides along on every cycle,
  // including the start cycle, to exercise the serve/drop boundaries.
  task automatic load(input tbl_t data, input int gap_pct, input logic exp_err,
                      output int cyc);
    int beat;
    logic [IN_BITS-1:0] code;
    code         = IN_BITS'($urandom);
    cfg_start    = 1'b1;
    cfg_valid    = 1'($urandom_range(0, 1));
    cfg_data     = ~data[0];
    lut_in_valid = 1'b1;
    lut_in       = code;
    step();
    if (resident) begin
      chk("start_lk_valid", lut_out_valid, 1);
      chk("start_lk_data", lut_out, cur_tbl[code]);
      last_out = cur_tbl[code];
    end else begin
      chk("start_lk_drop", lut_drop, 1);
    end
    resident = 0;
    chk("start_ready", cfg_ready, 1);
    chk("start_done", cfg_done, 0);
    chk("start_err", cfg_err, exp_err);
    cfg_start = 1'b0;
    beat = 0;
    cyc  = 1;
    while (!cfg_done && cyc < 3000) begin
      cfg_valid    = ($urandom_range(0, 99) >= gap_pct);
      cfg_data     = (beat < DEPTH) ? data[beat] : '0;
      lut_in_valid = 1'b1;
      lut_in       = IN_BITS'($urandom);
      step();
      cyc++;
      if (cfg_valid) beat++;
      chk("load_drop", lut_drop, 1);
      chk("load_valid", lut_out_valid, 0);
      chk("load_hold", lut_out, last_out);
      if (!cfg_done) chk("load_err", cfg_err, exp_err);
    end
    cfg_valid    = 1'b0;
    lut_in_valid = 1'b0;
    chk("done_beats", beat, DEPTH);
    chk("done", cfg_done, 1);
    chk("done_ready", cfg_ready, 0);
    chk("done_err", cfg_err, 0);
    cur_tbl  = data;
    resident = 1;
  endtask

  // Start a load and feed n beats without finishing it.
  task automatic partial(input int n);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    resident  = 0;
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = OUT_BITS'($urandom);
      step();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl_t t;
    int   cyc;
    rst_n = 1'b0;
    cfg_start = 0; cfg_valid = 0; cfg_data = '0;
    lut_in_valid = 0; lut_in = '0;
    resident = 0; last_out = '0;
    repeat (3) step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    chk_reset_outputs("idle");

    // Idle lookup is dropped, and the drop is a single pulse.
    look(6'd5);
    step();
    chk("drop_pulse", lut_drop, 0);
    chk("drop_out", lut_out, 0);

    // Full load of k[0]^k[3] without gaps.
    for (int k = 0; k < DEPTH; k++) t[k] = OUT_BITS'(k[0] ^ k[3]);
    load(t, 0, 1'b0, cyc);
    chk("load_cycles", cyc, 65);
    look(6'd8); chk("k8", lut_out, 1);
    look(6'd9); chk("k9", lut_out, 0);
    look(6'd1); chk("k1", lut_out, 1);
    look(6'd63); chk("k63", lut_out, 0);

    // All-ones table with random gaps.
    for (int k = 0; k < DEPTH; k++) t[k] = '1;
    load(t, 40, 1'b0, cyc);
    sweep();

    // Abort after 10 beats, then a clean all-zeros load.
    partial(10);
    chk("pre_abort_err", cfg_err, 0);
    for (int k = 0; k < DEPTH; k++) t[k] = '0;
    load(t, 0, 1'b1, cyc);
    sweep();

    // Reload from READY with a random table.
    for (int k = 0; k < DEPTH; k++) t[k] = OUT_BITS'($urandom);
    load(t, 20, 1'b0, cyc);
    sweep();

    // Abort to raise cfg_err, then reset in the middle of the next load.
    partial(5);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("abort_err", cfg_err, 1);
    for (int i = 0; i < 30; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = OUT_BITS'($urandom);
      step();
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    rst_n    = 1'b1;
    resident = 0;
    last_out = '0;
    step();
    chk_reset_outputs("post_rst");
    look(IN_BITS'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_neuron_loader.md
# lut_neuron_loader

Runtime-programmable LogicNets neuron. It loads a 2^IN_BITS-entry truth table over a streaming configuration port, stores it in distributed registers, and serves registered lookups with the same input-code-to-output mapping a fixed neuron ROM uses. It sits between the configuration controller, which writes tables, and the layer datapath, which reads neuron outputs. It lets one bitstream host retrained networks without resynthesis.

## Interface
- IN_BITS, 6, fan-in code width; table depth DEPTH = 2^IN_BITS.
- OUT_BITS, 1, output width per table entry.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse that begins or restarts a table load.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts a beat (high only in LOAD).
- cfg_data  in  OUT_BITS  table entry for the current load address.
- cfg_done  out  1  a complete table is resident (high in READY).
- cfg_err  out  1  sticky; set when a load is aborted by cfg_start.
- lut_in_valid  in  1  lookup request.
- lut_in  in  IN_BITS  input code (bit 0 = first fan-in bit).
- lut_out_valid  out  1  lut_out is valid.
- lut_out  out  OUT_BITS  table[lut_in] of the accepted request.
- lut_drop  out  1  one-cycle pulse when a lookup arrives while not READY.

## Operation
- FSM states: EMPTY, LOAD, READY.
  - EMPTY is entered at reset. No table is resident.
  - EMPTY or READY –cfg_start→ LOAD: load address is set to 0.
  - LOAD → READY: on the accepted beat at address DEPTH-1.
  - LOAD –cfg_start→ LOAD: load address restarts at 0 and cfg_err is set.
- Beat acceptance:
  - A beat is accepted when cfg_valid & cfg_ready and cfg_start is low.
  - An accepted beat writes table[addr] <= cfg_data, then addr increments.
  - Beat k is written to entry k, so entry index equals the input code.
- The address counter is IN_BITS+1 bits wide. It never wraps; reaching DEPTH-1 ends the load.
- cfg_start has priority over a beat in the same cycle. That beat is not written and not consumed.
- Table contents are not cleared on cfg_start. Entries are overwritten as the load proceeds, but lookups are blocked until READY.
- cfg_err is cleared only by completing a full load (the LOAD→READY transition) or by reset.
- Lookups:
  - In READY, lut_in_valid=1 is registered as lut_out_valid=1 and lut_out=table[lut_in] on the next cycle.
  - In EMPTY or LOAD, the request is dropped: lut_drop=1 next cycle and lut_out_valid=0.
  - There is no backpressure on the lookup path. A new request can be issued every cycle.
- lut_out holds its last value when lut_out_valid=0.

## Timing
- Reset values:
  - Outputs: cfg_ready=0, cfg_done=0, cfg_err=0, lut_out_valid=0, lut_out=0, lut_drop=0.
  - Internal: all table entries 0, addr=0, state EMPTY.
- cfg_start in cycle t:
  - State is LOAD from t+1.
  - cfg_ready=1 at t+1.
  - cfg_done=0 at t+1.
- The load with no stalls takes DEPTH cycles. The last beat is accepted in cycle t+DEPTH.
- After the last beat: cfg_ready=0 and cfg_done=1 at t+DEPTH+1.
- Lookup latency is exactly 1 cycle. Throughput is 1 lookup per cycle.
- Simultaneous events:
  - Lookup and cfg_start in the same cycle while READY: the lookup is served from the old table (state is still READY in that cycle). Lookups from the next cycle on are dropped.
  - Lookup in the same cycle as the final beat: the lookup is dropped, because state is LOAD that cycle. The first served lookup is the one presented in the cycle READY is entered.
- cfg_valid gaps stall the load indefinitely with no timeout. addr holds during a gap.
- rst_n asserted mid-load: immediate return to EMPTY, table cleared, cfg_err=0.

## Test plan
- Reset then idle: all outputs 0. A lookup with lut_in=6'd5 gives lut_drop=1 and lut_out_valid=0 one cycle later.
- Full load, no gaps, with entry k = k[0]^k[3]:
  - cfg_done rises exactly 65 cycles after cfg_start.
  - Then lookups 6'd8→1, 6'd9→0, 6'd1→1, 6'd63→0, each with 1-cycle latency on back-to-back cycles.
- Load with random cfg_valid gaps using an all-ones table: cfg_done rises only after 64 accepted beats, and every code 0..63 returns 1.
- Abort: cfg_start after 10 beats, then a full load of all zeros.
  - cfg_err=1 from the abort until cfg_done rises, then 0.
  - Every lookup returns 0.
- Reload from READY:
  - A lookup in the cfg_start cycle returns the old entry.
  - The next-cycle lookup is dropped.
  - After the reload, the new values are returned.
- Assert rst_n at beat 30 of a load: outputs return to their reset values, and state is EMPTY after release.
